xdma_bypass_splitter: RTL and testbench

//   Host-side DMA request splitter for one XDMA bypass channel (H2C or C2H). Accepts dmaIntf-style

---
 rtl/xdma_bypass_splitter.sv | 93 +++++++++
 tb/tb_xdma_bypass_splitter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xdma_bypass_splitter.sv
// xdma_bypass_splitter: cuts host DMA requests into 2^CHUNK_BITS-aligned XDMA bypass descriptors
// Ports: aclk/areset clock and async active-high reset; req_addr/req_len/req_ctl/req_valid/req_ready
// request in, req_done pulse when all its descriptors completed; x_addr/x_len/x_ctl/x_valid/x_ready
// descriptor out, x_status[1] completion pulse in; busy, outstanding count, sticky err_spurious.
module xdma_bypass_splitter #(
  parameter int ADDR_BITS = 64,
  parameter int LEN_BITS = 28,
  parameter int CHUNK_BITS = 12,
  parameter int N_OUTSTANDING = 16
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic [ADDR_BITS-1:0]             req_addr,
  input  logic [LEN_BITS-1:0]              req_len,
  input  logic [15:0]                      req_ctl,
  input  logic                             req_valid,
  output logic                             req_ready,
  output logic                             req_done,
  output logic [ADDR_BITS-1:0]             x_addr,
  output logic [LEN_BITS-1:0]              x_len,
  output logic [15:0]                      x_ctl,
  output logic                             x_valid,
  input  logic                             x_ready,
  input  logic [7:0]                       x_status,
  output logic                             busy,
  output logic [$clog2(N_OUTSTANDING):0]   outstanding,
  output logic                             err_spurious
);
  localparam int OW = $clog2(N_OUTSTANDING) + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_BITS-1:0] cur_addr, src_addr;
  logic [LEN_BITS-1:0] rem, src_rem, chunk;
  logic [LEN_BITS:0] room;
  logic [15:0] ctl, src_ctl;
  logic hs, comp, dec, load;
  logic [OW-1:0] out_nx;
  logic unused_status;
  assign unused_status = ^{x_status[7:2], x_status[0]};
  assign hs = x_valid & x_ready;
  assign comp = x_status[1];
  // a completion with nothing outstanding is not counted, only flagged
  assign dec = comp & (outstanding != '0);
  assign out_nx = outstanding + OW'(hs) - OW'(dec);
  // in IDLE the first descriptor is built straight from the request so it appears the next cycle
  assign src_addr = (state == IDLE) ? req_addr : cur_addr;
  assign src_rem = (state == IDLE) ? req_len : rem;
  assign src_ctl = (state == IDLE) ? req_ctl : ctl;
  assign room = (LEN_BITS+1)'(2**CHUNK_BITS) - (LEN_BITS+1)'(src_addr[CHUNK_BITS-1:0]);
  assign chunk = ({1'b0, src_rem} < room) ? src_rem : room[LEN_BITS-1:0];
  // load when the slot frees this cycle and the new descriptor still fits the outstanding window
  assign load = ((state == IDLE) ? req_valid : (state == ISSUE)) && (src_rem != '0)
                && (!x_valid || x_ready) && (out_nx < OW'(N_OUTSTANDING));
  assign req_ready = (state == IDLE);
  assign busy = (state != IDLE);
  assign req_done = (state == DONE);
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE)  ? (req_valid ? ((req_len == '0) ? DRAIN : ISSUE) : IDLE) :
               (state == ISSUE) ? ((hs && x_ctl[0]) ? DRAIN : ISSUE) :
               (state == DRAIN) ? ((out_nx == '0) ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cur_addr <= '0;
      rem <= '0;
      ctl <= '0;
      x_addr <= '0;
      x_len <= '0;
      x_ctl <= '0;
      x_valid <= 1'b0;
      outstanding <= '0;
      err_spurious <= 1'b0;
    end else begin
      outstanding <= out_nx;
      err_spurious <= err_spurious | (comp & (outstanding == '0));
      if (hs) x_valid <= 1'b0;
      if (state == IDLE && req_valid) ctl <= req_ctl;
      if (load) begin
        x_addr <= src_addr;
        x_len <= chunk;
        x_ctl <= {src_ctl[15:1], chunk == src_rem};
        x_valid <= 1'b1;
        cur_addr <= src_addr + ADDR_BITS'(chunk);
        rem <= src_rem - chunk;
      end
    end
  end
endmodule

// File: tb/tb_xdma_bypass_splitter.sv
// tb_xdma_bypass_splitter: randomized self-checking bench for xdma_bypass_splitter
module tb_xdma_bypass_splitter;
  localparam int NO = 16;
  typedef struct packed {logic [63:0] a; logic [27:0] l; logic [15:0] c;} desc_t;
  logic aclk = 0, areset = 1;
  logic [63:0] req_addr = '0;
  logic [27:0] req_len = '0;
  logic [15:0] req_ctl = '0;
  logic req_valid = 0;
  logic req_ready, req_done, x_valid, busy, err_spurious;
  logic [63:0] x_addr;
  logic [27:0] x_len;
  logic [15:0] x_ctl;
  logic x_ready = 1;
  logic [7:0] x_status = '0;
  logic [4:0] outstanding;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  desc_t got[$], exp_q[$];
  int pend[$];
  int comp_idx = 0, spur_req = 0, spur_ack = 0, cdly_lo = 1, cdly_hi = 1;
  bit comp_hold = 0, xr_rand = 0;
  int m_out = 0, done_n = 0, last_done = -1, last_comp = -1;
  bit m_err = 0, p_stall = 0, chk_ready = 0;
  desc_t p;

  xdma_bypass_splitter dut (
    .aclk(aclk), .areset(areset), .req_addr(req_addr), .req_len(req_len), .req_ctl(req_ctl),
    .req_valid(req_valid), .req_ready(req_ready), .req_done(req_done), .x_addr(x_addr),
    .x_len(x_len), .x_ctl(x_ctl), .x_valid(x_valid), .x_ready(x_ready), .x_status(x_status),
    .busy(busy), .outstanding(outstanding), .err_spurious(err_spurious)
  );

  initial forever #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  function automatic void model(input logic [63:0] a, input logic [27:0] l, input logic [15:0] c);
    longint unsigned rem, room, ch;
    logic [63:0] ad;
    rem = l;
    ad = a;
    exp_q.delete();
    while (rem > 0) begin
      room = 4096 - (ad % 4096);
      ch = (rem < room) ? rem : room;
      exp_q.push_back({ad, 28'(ch), c[15:1], (rem == ch)});
      ad += ch;
      rem -= ch;
    end
  endfunction

  task automatic driver();
    forever begin
      @(posedge aclk);
      #1;
      x_ready = xr_rand ? 1'($urandom_range(1, 0)) : 1'b1;
      x_status = 8'($urandom) & 8'hFD;
      if (areset) comp_idx = pend.size();
      else if (spur_ack != spur_req) begin
        x_status[1] = 1'b1;
        spur_ack++;
      end else if (!comp_hold && comp_idx < pend.size() && pend[comp_idx] <= cyc) begin
        x_status[1] = 1'b1;
        comp_idx++;
      end
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge aclk);
      if (areset) begin
        m_out = 0; m_err = 0; p_stall = 0; chk_ready = 0;
      end else begin
        n_cmp++;
        if (outstanding !== 5'(m_out)) begin
          n_bad++; $display("FAIL outstanding cyc %0d: got %0d expected %0d", cyc, outstanding, m_out);
        end
        n_cmp++;
        if (err_spurious !== m_err) begin
          n_bad++; $display("FAIL err_spurious cyc %0d: got %b expected %b", cyc, err_spurious, m_err);
        end
        n_cmp++;
        if (m_out + int'(x_valid) > NO) begin
          n_bad++; $display("FAIL window cyc %0d: got %0d in flight expected <= %0d", cyc, m_out + int'(x_valid), NO);
        end
        if (p_stall) begin
          n_cmp++;
          if (x_valid !== 1'b1 || {x_addr, x_len, x_ctl} !== p) begin
            n_bad++; $display("FAIL stall_hold cyc %0d: got v=%b %h expected v=1 %h", cyc, x_valid, {x_addr, x_len, x_ctl}, p);
          end
        end
        if (chk_ready) begin
          n_cmp++;
          if (req_ready !== 1'b1) begin
            n_bad++; $display("FAIL ready_after_done cyc %0d: got %b expected 1", cyc, req_ready);
          end
          chk_ready = 0;
        end
        if (req_done) begin
          n_cmp++;
          if (req_ready !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL done_state cyc %0d: got ready=%b busy=%b expected 0/1", cyc, req_ready, busy);
          end
          done_n++; last_done = cyc; chk_ready = 1;
        end
        if (x_valid && x_ready) begin
          got.push_back({x_addr, x_len, x_ctl});
          pend.push_back(cyc + int'($urandom_range(cdly_hi, cdly_lo)));
        end
        p_stall = x_valid && !x_ready;
        p = {x_addr, x_len, x_ctl};
        if (x_status[1]) begin
          if (m_out == 0) m_err = 1;
          else begin m_out--; last_comp = cyc; end
        end
        if (x_valid && x_ready) m_out++;
      end
    end
  endtask

  task automatic issue_req(input logic [63:0] a, input logic [27:0] l, input logic [15:0] c,
                           output int hs, output bit ok);
    ok = 0; hs = -1;
    @(posedge aclk);
    #1;
    req_addr = a; req_len = l; req_ctl = c; req_valid = 1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge aclk);
      if (req_ready) begin ok = 1; hs = cyc; end
    end
    @(posedge aclk);
    #1;
    req_valid = 0; req_addr = {$urandom, $urandom}; req_len = 28'($urandom); req_ctl = 16'($urandom);
  endtask

  task automatic wait_done(input int d0, input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge aclk);
      #1;
      ok = done_n > d0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge aclk);
    n_cmp++;
    if ({req_ready, req_done, x_valid, busy, err_spurious} !== 5'b10000) begin
      n_bad++; $display("FAIL reset_ctrl: got %b expected 10000", {req_ready, req_done, x_valid, busy, err_spurious});
    end
    n_cmp++;
    if ({outstanding, x_ctl, x_len, x_addr} !== '0) begin
      n_bad++; $display("FAIL reset_data: got %h expected 0", {outstanding, x_ctl, x_len, x_addr});
    end
    @(posedge aclk);
    #1 areset = 0;
  endtask

  task automatic test_directed();
    logic [63:0] ta [2] = '{64'h1000, 64'h0FF0};
    logic [27:0] tl [2] = '{28'h3000, 28'h40};
    int hs, g0, d0;
    bit ok;
    xr_rand = 0; comp_hold = 0; cdly_lo = 5; cdly_hi = 5;
    for (int k = 0; k < 2; k++) begin
      model(ta[k], tl[k], 16'h1235);
      g0 = got.size(); d0 = done_n;
      issue_req(ta[k], tl[k], 16'h1235, hs, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL dir_accept[%0d]: got no handshake expected one", k); end
      @(negedge aclk);
      n_cmp++;
      if (x_valid !== 1'b1) begin n_bad++; $display("FAIL dir_first_valid[%0d]: got %b expected 1", k, x_valid); end
      wait_done(d0, 300, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL dir_done_timeout[%0d]: got no req_done expected one", k); end
      n_cmp++;
      if (last_done !== last_comp + 1) begin
        n_bad++; $display("FAIL dir_done_latency[%0d]: got cyc %0d expected %0d", k, last_done, last_comp + 1);
      end
      n_cmp++;
      if (got.size() - g0 !== exp_q.size()) begin
        n_bad++; $display("FAIL dir_count[%0d]: got %0d expected %0d", k, got.size() - g0, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && g0 + i < got.size(); i++) begin
        n_cmp++;
        if (got[g0+i] !== exp_q[i]) begin
          n_bad++; $display("FAIL dir_desc[%0d][%0d]: got %h expected %h", k, i, got[g0+i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_zero_len();
    int hs, g0, d0;
    bit ok;
    g0 = got.size(); d0 = done_n;
    issue_req(64'h5000, 28'h0, 16'hFFFF, hs, ok);
    @(negedge aclk);
    n_cmp++;
    if (x_valid !== 1'b0) begin n_bad++; $display("FAIL zero_valid: got %b expected 0", x_valid); end
    wait_done(d0, 20, ok);
    n_cmp++;
    if (!ok || last_done !== hs + 2) begin
      n_bad++; $display("FAIL zero_done: got cyc %0d (seen %b) expected %0d", last_done, ok, hs + 2);
    end
    repeat (2) @(negedge aclk);
    n_cmp++;
    if (got.size() !== g0 || done_n !== d0 + 1) begin
      n_bad++; $display("FAIL zero_counts: got descs %0d dones %0d expected 0 and 1", got.size() - g0, done_n - d0);
    end
  endtask

  task automatic test_backpressure();
    int hs, g0, d0;
    bit ok;
    xr_rand = 0; comp_hold = 1; cdly_lo = 1; cdly_hi = 3;
    model(64'h0, 28'h20000, 16'hA5A4);
    g0 = got.size(); d0 = done_n;
    issue_req(64'h0, 28'h20000, 16'hA5A4, hs, ok);
    repeat (60) @(negedge aclk);
    #1;
    n_cmp++;
    if (got.size() - g0 !== NO) begin n_bad++; $display("FAIL bp_issued: got %0d expected %0d", got.size() - g0, NO); end
    n_cmp++;
    if (x_valid !== 1'b0 || outstanding !== 5'(NO)) begin
      n_bad++; $display("FAIL bp_full: got v=%b out=%0d expected v=0 out=%0d", x_valid, outstanding, NO);
    end
    comp_hold = 0;
    wait_done(d0, 600, ok);
    n_cmp++;
    if (!ok || last_done !== last_comp + 1) begin
      n_bad++; $display("FAIL bp_done: got cyc %0d (seen %b) expected %0d", last_done, ok, last_comp + 1);
    end
    n_cmp++;
    if (got.size() - g0 !== exp_q.size()) begin
      n_bad++; $display("FAIL bp_count: got %0d expected %0d", got.size() - g0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && g0 + i < got.size(); i++) begin
      n_cmp++;
      if (got[g0+i] !== exp_q[i]) begin n_bad++; $display("FAIL bp_desc[%0d]: got %h expected %h", i, got[g0+i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    int hs, g0, d0;
    bit ok;
    xr_rand = 1; comp_hold = 0; cdly_lo = 1; cdly_hi = 8;
    for (int k = 0; k < 12; k++) begin
      logic [63:0] a;
      logic [27:0] l;
      logic [15:0] c;
      a = {$urandom, $urandom};
      if (k % 4 == 1) a = 64'hFFFF_FFFF_FFFF_F000 | 64'($urandom_range(4095, 0));
      l = (k % 5 == 3) ? 28'd0 : 28'($urandom_range(12288, 1));
      c = 16'($urandom);
      model(a, l, c);
      g0 = got.size(); d0 = done_n;
      issue_req(a, l, c, hs, ok);
      @(negedge aclk);
      n_cmp++;
      if (x_valid !== (l != 0)) begin n_bad++; $display("FAIL rnd_first_valid[%0d]: got %b expected %b", k, x_valid, l != 0); end
      wait_done(d0, 1000, ok);
      n_cmp++;
      if (!ok || last_done !== ((l == 0) ? hs + 2 : last_comp + 1)) begin
        n_bad++; $display("FAIL rnd_done[%0d]: got cyc %0d (seen %b) expected %0d", k, last_done, ok,
                          (l == 0) ? hs + 2 : last_comp + 1);
      end
      n_cmp++;
      if (got.size() - g0 !== exp_q.size()) begin
        n_bad++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", k, got.size() - g0, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && g0 + i < got.size(); i++) begin
        n_cmp++;
        if (got[g0+i] !== exp_q[i]) begin
          n_bad++; $display("FAIL rnd_desc[%0d][%0d]: got %h expected %h", k, i, got[g0+i], exp_q[i]);
        end
      end
    end
    xr_rand = 0;
  endtask

  task automatic test_spurious();
    repeat (2) @(negedge aclk);
    spur_req++;
    repeat (3) @(negedge aclk);
    #1;
    n_cmp++;
    if (err_spurious !== 1'b1 || outstanding !== 5'd0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL spurious: got err=%b out=%0d busy=%b expected 1/0/0", err_spurious, outstanding, busy);
    end
  endtask

  task automatic test_reset_mid();
    int hs, g0, d0;
    bit ok;
    comp_hold = 1; xr_rand = 0;
    issue_req(64'h4000, 28'h20000, 16'h0, hs, ok);
    repeat (5) @(negedge aclk);
    #2 areset = 1;
    #1;
    n_cmp++;
    if ({req_ready, req_done, x_valid, busy, err_spurious} !== 5'b10000) begin
      n_bad++; $display("FAIL midreset_ctrl: got %b expected 10000", {req_ready, req_done, x_valid, busy, err_spurious});
    end
    n_cmp++;
    if ({outstanding, x_ctl, x_len, x_addr} !== '0) begin
      n_bad++; $display("FAIL midreset_data: got %h expected 0", {outstanding, x_ctl, x_len, x_addr});
    end
    d0 = done_n;
    repeat (2) @(posedge aclk);
    #1 areset = 0;
    comp_hold = 0;
    g0 = got.size();
    repeat (30) @(negedge aclk);
    #1;
    n_cmp++;
    if (done_n !== d0 || got.size() !== g0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL midreset_quiet: got dones %0d descs %0d busy %b expected 0/0/0", done_n - d0, got.size() - g0, busy);
    end
  endtask

  initial begin
    fork
      monitor();
      driver();
    join_none
    test_reset();
    test_directed();
    test_zero_len();
    test_backpressure();
    test_random();
    test_spurious();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
